write_buffer: RTL and testbench

Posted-write buffer between the data cache's memory port and dmem. Absorbs write-backs from the cache into a small FIFO so the pipeline does not stall on each memory write. Drains entries to memory in order with a request/ready handshake. Serialises cache line-fill reads behind all pending writes, so memory is never read stale.

---
 rtl/write_buffer.sv | 147 ++++++++++++++
 tb/tb_write_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer.sv
// Posted-write buffer: queues cache write-backs in a FIFO and drains them to memory
// in order, holding fill reads until every earlier write has completed.
module write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        WE,
  input  logic [31:0] WAddr,
  input  logic [31:0] WD,
  output logic        Full,
  output logic        Empty,
  input  logic        RE,
  input  logic [31:0] RAddr,
  output logic        RReady,
  output logic [31:0] RD,
  output logic        MReq,
  output logic        MWE,
  output logic [31:0] MAddr,
  output logic [31:0] MWD,
  input  logic        MReady,
  input  logic [31:0] MRD
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RDONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   addr_mem_q [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic          mreq_q, mreq_d, mwe_q, mwe_d, rready_q, rready_d;
  logic [31:0]   maddr_q, maddr_d, mwd_q, mwd_d, rd_q, rd_d;
  logic          push, pop;

  // RE forces Full so that no new write can slip in ahead of a pending fill read.
  assign Full   = (count_q == FULL_CNT) | RE;
  assign Empty  = (count_q == {(AW+1){1'b0}});
  assign push   = WE & ~Full;
  assign MReq   = mreq_q;
  assign MWE    = mwe_q;
  assign MAddr  = maddr_q;
  assign MWD    = mwd_q;
  assign RReady = rready_q;
  assign RD     = rd_q;

  always_comb begin
    state_d  = state_q;
    mreq_d   = 1'b0;
    mwe_d    = 1'b0;
    maddr_d  = maddr_q;
    mwd_d    = mwd_q;
    rready_d = 1'b0;
    rd_d     = rd_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != {(AW+1){1'b0}}) begin
          state_d = S_WRITE;
          mreq_d  = 1'b1;
          mwe_d   = 1'b1;
          maddr_d = addr_mem_q[head_q];
          mwd_d   = data_mem_q[head_q];
        end else if (RE) begin
          state_d = S_READ;
          mreq_d  = 1'b1;
          maddr_d = RAddr;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (MReady) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end else begin
          mreq_d = 1'b1;
          mwe_d  = 1'b1;
        end
      end
      S_READ: begin
        if (MReady) begin
          rd_d     = MRD;
          rready_d = 1'b1;
          state_d  = S_RDONE;
        end else begin
          mreq_d = 1'b1;
        end
      end
      S_RDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(push);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      head_q   <= {AW{1'b0}};
      tail_q   <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      rready_q <= 1'b0;
      maddr_q  <= 32'h0;
      mwd_q    <= 32'h0;
      rd_q     <= 32'h0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      rready_q <= rready_d;
      maddr_q  <= maddr_d;
      mwd_q    <= mwd_d;
      rd_q     <= rd_d;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= 32'h0;
        data_mem_q[i] <= 32'h0;
      end
    end else if (push) begin
      addr_mem_q[tail_q] <= WAddr;
      data_mem_q[tail_q] <= WD;
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: a behavioural memory logs every completed
// transaction, and tests compare that log and the status outputs with hand values.
module tb_write_buffer;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        WE = 1'b0, RE = 1'b0, MReady = 1'b0;
  logic [31:0] WAddr = 32'h0, WD = 32'h0, RAddr = 32'h0, MRD = 32'h0;
  logic        Full, Empty, RReady, MReq, MWE;
  logic [31:0] RD, MAddr, MWD;

  write_buffer #(.DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset), .WE(WE), .WAddr(WAddr), .WD(WD),
    .Full(Full), .Empty(Empty), .RE(RE), .RAddr(RAddr), .RReady(RReady),
    .RD(RD), .MReq(MReq), .MWE(MWE), .MAddr(MAddr), .MWD(MWD),
    .MReady(MReady), .MRD(MRD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    int          w;
  } ent_t;

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        exp_full;
    logic        exp_empty;
  } vec_t;

  ent_t        log_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        stall = 1'b0;
  logic [31:0] rd_val = 32'h0;
  int          cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_ent(input string nm, input int idx, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    if (idx < log_q.size()) begin
      chk({nm, "_we"}, {31'h0, log_q[idx].we}, {31'h0, we});
      chk({nm, "_addr"}, log_q[idx].a, a);
      if (we) chk({nm, "_data"}, log_q[idx].d, d);
    end else begin
      chk({nm, "_present"}, log_q.size(), idx + 1);
    end
  endtask

  task automatic wait_log(input int n, input string nm);
    int k = 0;
    while (log_q.size() < n && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk(nm, log_q.size(), n);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    WE = 1'b1; WAddr = a; WD = d;
    @(negedge CLK);
    WE = 1'b0;
  endtask

  // Memory model: completes a request on its second MReq cycle unless stalled.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (!Reset) begin
        MReady = 1'b0; cnt = 0;
      end else if (MReady) begin
        MReady = 1'b0; cnt = 0;
        chk("mreq_drop", {31'h0, MReq}, 32'h0);
      end else if (MReq && !stall) begin
        if (cnt >= 1) begin
          MReady = 1'b1;
          MRD = MWE ? 32'h0 : rd_val;
          log_q.push_back('{MWE, MAddr, MWD, cnt + 1});
        end else begin
          cnt++;
        end
      end else if (!MReq) begin
        cnt = 0;
      end
    end
  end

  initial begin
    vec_t vt[7];
    int   k;
    vt[0] = '{1'b1, 32'h100, 32'hA1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 32'h104, 32'hA2, 1'b0, 1'b0};
    vt[2] = '{1'b1, 32'h108, 32'hA3, 1'b0, 1'b0};
    vt[3] = '{1'b1, 32'h10C, 32'hA4, 1'b1, 1'b0};
    vt[4] = '{1'b1, 32'h110, 32'hA5, 1'b1, 1'b0};
    vt[5] = '{1'b1, 32'h114, 32'hA6, 1'b1, 1'b0};
    vt[6] = '{1'b0, 32'h0,   32'h0,  1'b1, 1'b0};

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_empty", {31'h0, Empty}, 32'h1);
    chk("rst_full", {31'h0, Full}, 32'h0);
    Reset = 1'b1;
    @(negedge CLK);
    chk("rst_mreq", {31'h0, MReq}, 32'h0);
    chk("rst_rready", {31'h0, RReady}, 32'h0);
    chk("rst_rd", RD, 32'h0);
    chk("rst_maddr", MAddr, 32'h0);

    // Push/drain with a one-cycle memory
    WE = 1'b1; WAddr = 32'h0; WD = 32'hE;
    @(negedge CLK);
    chk("t1_empty_after_push", {31'h0, Empty}, 32'h0);
    chk("t1_mreq_not_yet", {31'h0, MReq}, 32'h0);
    WAddr = 32'h4; WD = 32'hF;
    @(negedge CLK);
    chk("t1_mreq_rise", {31'h0, MReq}, 32'h1);
    chk("t1_mwe", {31'h0, MWE}, 32'h1);
    chk("t1_maddr", MAddr, 32'h0);
    chk("t1_mwd", MWD, 32'hE);
    WAddr = 32'h8; WD = 32'h10;
    @(negedge CLK);
    WE = 1'b0;
    wait_log(3, "t1_writes");
    chk_ent("t1_w0", 0, 1'b1, 32'h0, 32'hE);
    chk_ent("t1_w1", 1, 1'b1, 32'h4, 32'hF);
    chk_ent("t1_w2", 2, 1'b1, 32'h8, 32'h10);
    for (int i = 0; i < 3 && i < log_q.size(); i++) chk("t1_mreq_width", log_q[i].w, 32'd2);
    repeat (2) @(negedge CLK);
    chk("t1_empty_end", {31'h0, Empty}, 32'h1);

    // Fill to full with memory stalled: table-driven
    log_q.delete();
    stall = 1'b1;
    for (int i = 0; i < 7; i++) begin
      WE = vt[i].we; WAddr = vt[i].wa; WD = vt[i].wd;
      @(negedge CLK);
      chk($sformatf("t2_full_v%0d", i), {31'h0, Full}, {31'h0, vt[i].exp_full});
      chk($sformatf("t2_empty_v%0d", i), {31'h0, Empty}, {31'h0, vt[i].exp_empty});
    end
    WE = 1'b0;
    stall = 1'b0;
    wait_log(4, "t2_writes");
    repeat (12) @(negedge CLK);
    chk("t2_only_four", log_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk_ent($sformatf("t2_w%0d", i), i, 1'b1, 32'h100 + 32'(4 * i), 32'hA1 + 32'(i));
    chk("t2_empty_end", {31'h0, Empty}, 32'h1);

    // Read behind writes; pushes during RE are rejected
    log_q.delete();
    rd_val = 32'hF;
    push(32'h300, 32'h31);
    push(32'h304, 32'h32);
    RE = 1'b1; RAddr = 32'h4;
    WE = 1'b1; WAddr = 32'h999; WD = 32'h99;
    #1;
    chk("t3_full_on_re", {31'h0, Full}, 32'h1);
    k = 0;
    while (RReady !== 1'b1 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    chk("t3_rready_seen", {31'h0, RReady}, 32'h1);
    chk("t3_rd", RD, 32'hF);
    RE = 1'b0; WE = 1'b0;
    @(negedge CLK);
    chk("t3_rready_pulse", {31'h0, RReady}, 32'h0);
    chk("t3_rd_hold", RD, 32'hF);
    repeat (10) @(negedge CLK);
    chk("t3_txn_count", log_q.size(), 32'd3);
    chk_ent("t3_w0", 0, 1'b1, 32'h300, 32'h31);
    chk_ent("t3_w1", 1, 1'b1, 32'h304, 32'h32);
    chk_ent("t3_rd_req", 2, 1'b0, 32'h4, 32'h0);
    chk("t3_empty", {31'h0, Empty}, 32'h1);

    // Wrap-around: ten push/drain pairs
    log_q.delete();
    for (int i = 0; i < 10; i++) begin
      push(32'h200 + 32'(4 * i), 32'h5000 + 32'(i));
      wait_log(i + 1, $sformatf("t4_drain%0d", i));
      chk_ent($sformatf("t4_w%0d", i), i, 1'b1, 32'h200 + 32'(4 * i), 32'h5000 + 32'(i));
    end
    repeat (2) @(negedge CLK);

    // Simultaneous push and pop at count 2
    log_q.delete();
    stall = 1'b1;
    push(32'h400, 32'h41);
    push(32'h404, 32'h42);
    stall = 1'b0;
    k = 0;
    while (MReady !== 1'b1 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk("t5_mready_seen", {31'h0, MReady}, 32'h1);
    WE = 1'b1; WAddr = 32'h408; WD = 32'h43;
    @(negedge CLK);
    WE = 1'b0;
    stall = 1'b1;
    chk("t5_full_cnt2", {31'h0, Full}, 32'h0);
    chk("t5_empty_cnt2", {31'h0, Empty}, 32'h0);
    push(32'h40C, 32'h44);
    chk("t5_full_cnt3", {31'h0, Full}, 32'h0);
    push(32'h410, 32'h45);
    chk("t5_full_cnt4", {31'h0, Full}, 32'h1);
    stall = 1'b0;
    wait_log(5, "t5_writes");
    for (int i = 0; i < 5; i++)
      chk_ent($sformatf("t5_w%0d", i), i, 1'b1, 32'h400 + 32'(4 * i), 32'h41 + 32'(i));
    repeat (4) @(negedge CLK);

    // Reset mid-WRITE with three entries buffered
    log_q.delete();
    stall = 1'b1;
    push(32'h500, 32'h51);
    push(32'h504, 32'h52);
    push(32'h508, 32'h53);
    chk("t6_mreq_before", {31'h0, MReq}, 32'h1);
    Reset = 1'b0;
    #1;
    chk("t6_mreq", {31'h0, MReq}, 32'h0);
    chk("t6_mwe", {31'h0, MWE}, 32'h0);
    chk("t6_rready", {31'h0, RReady}, 32'h0);
    chk("t6_empty", {31'h0, Empty}, 32'h1);
    chk("t6_full", {31'h0, Full}, 32'h0);
    chk("t6_maddr", MAddr, 32'h0);
    chk("t6_mwd", MWD, 32'h0);
    chk("t6_rd", RD, 32'h0);
    @(negedge CLK);
    Reset = 1'b1;
    stall = 1'b0;
    repeat (20) @(negedge CLK);
    chk("t6_no_writes", log_q.size(), 32'd0);
    chk("t6_mreq_after", {31'h0, MReq}, 32'h0);
    chk("t6_empty_after", {31'h0, Empty}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
